// File: rtl/pipe_exe_stage.sv
// EXE stage: ALU / JAL link / iterative multu-divu with HI/LO, registered into EX/MEM.
// One cycle through EX/MEM for ALU ops; multu/divu hold estall for 33 cycles and then retire.
module pipe_exe_stage #(
    parameter int XLEN      = 32,
    parameter bit MD_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic            ewmem,
    input  logic [3:0]      ealuc,
    input  logic            ealuimm,
    input  logic            eshift,
    input  logic            ejal,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic [XLEN-1:0] eimm,
    input  logic [XLEN-1:0] epc4,
    input  logic [4:0]      ern,
    input  logic [2:0]      emd,
    output logic [XLEN-1:0] ealu,
    output logic            estall,
    output logic            mwreg,
    output logic            mm2reg,
    output logic            mwmem,
    output logic [XLEN-1:0] malu,
    output logic [XLEN-1:0] mb,
    output logic [4:0]      mrn
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t         md_state_q, md_state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              mwreg_q, mwreg_d, mm2reg_q, mm2reg_d, mwmem_q, mwmem_d;
    logic [XLEN-1:0]   malu_q, malu_d, mb_q, mb_d;
    logic [4:0]        mrn_q, mrn_d;

    logic [XLEN-1:0]   alu_a, alu_b, alu_res, sra_res;
    logic [4:0]        sa;
    logic [2:0]        md_sel;
    logic              md_start;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_rem;
    logic              div_ge;
    logic [2*XLEN-1:0] step_acc;

    always_comb begin
        alu_a   = eshift ? {{(XLEN-5){1'b0}}, eimm[10:6]} : ea;
        alu_b   = ealuimm ? eimm : eb;
        sa      = alu_a[4:0];
        sra_res = $signed(alu_b) >>> sa;
        alu_res = '0;
        case (ealuc[2:0])
            3'b000: alu_res = alu_a + alu_b;
            3'b100: alu_res = alu_a - alu_b;
            3'b001: alu_res = alu_a & alu_b;
            3'b101: alu_res = alu_a | alu_b;
            3'b010: alu_res = alu_a ^ alu_b;
            3'b110: alu_res = alu_b << 16;
            3'b011: alu_res = alu_b << sa;
            3'b111: alu_res = ealuc[3] ? sra_res : (alu_b >> sa);
        endcase
    end

    // With the unit disabled every emd decodes as a plain ALU op.
    always_comb begin
        md_sel   = MD_ENABLE ? emd : 3'b000;
        md_start = (md_state_q == MD_IDLE) && (md_sel == 3'b001 || md_sel == 3'b010);
        estall   = !clrn && (md_start || md_state_q == MD_BUSY);
        if (ejal)                   ealu = epc4 + XLEN'(4);
        else if (md_sel == 3'b011)  ealu = hi_q;
        else if (md_sel == 3'b100)  ealu = lo_q;
        else                        ealu = alu_res;
    end

    // One radix-2 step: acc holds {partial, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];
        step_acc  = is_div_q ? {div_rem, acc_q[XLEN-2:0], div_ge}
                             : {mul_sum, acc_q[XLEN-1:1]};
    end

    always_comb begin
        md_state_d = md_state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (md_state_q)
            MD_IDLE: if (md_start) begin
                md_state_d = MD_BUSY;
                cnt_d      = '0;
                acc_d      = {{XLEN{1'b0}}, ea};
                opnd_d     = eb;
                is_div_d   = (md_sel == 3'b010);
            end
            MD_BUSY: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    hi_d       = step_acc[2*XLEN-1:XLEN];
                    lo_d       = step_acc[XLEN-1:0];
                    cnt_d      = '0;
                    md_state_d = MD_DONE;
                end
            end
            MD_DONE: md_state_d = MD_IDLE;
            default: md_state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        mwreg_d  = estall ? 1'b0 : ewreg;
        mm2reg_d = estall ? 1'b0 : em2reg;
        mwmem_d  = estall ? 1'b0 : ewmem;
        malu_d   = estall ? '0 : ealu;
        mb_d     = estall ? '0 : eb;
        mrn_d    = estall ? '0 : ern;
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            md_state_q <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            mwreg_q    <= 1'b0;
            mm2reg_q   <= 1'b0;
            mwmem_q    <= 1'b0;
            malu_q     <= '0;
            mb_q       <= '0;
            mrn_q      <= '0;
        end else begin
            md_state_q <= md_state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mwreg_q    <= mwreg_d;
            mm2reg_q   <= mm2reg_d;
            mwmem_q    <= mwmem_d;
            malu_q     <= malu_d;
            mb_q       <= mb_d;
            mrn_q      <= mrn_d;
        end
    end

    assign mwreg  = mwreg_q;
    assign mm2reg = mm2reg_q;
    assign mwmem  = mwmem_q;
    assign malu   = malu_q;
    assign mb     = mb_q;
    assign mrn    = mrn_q;
endmodule

// File: tb/tb_pipe_exe_stage.sv
// Scoreboarded bench for pipe_exe_stage: directed cases plus random instructions vs. an arithmetic model.
module tb_pipe_exe_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn;
    logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [3:0]  ealuc;
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern;
    logic [2:0]  emd;
    logic [31:0] ealu, malu, mb;
    logic        estall, mwreg, mm2reg, mwmem;
    logic [4:0]  mrn;

    pipe_exe_stage #(.XLEN(32), .MD_ENABLE(1'b1)) dut (
        .clk(clk), .clrn(clrn), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal),
        .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern(ern), .emd(emd),
        .ealu(ealu), .estall(estall), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn)
    );

    typedef struct {
        logic        wreg, m2reg, wmem, aluimm, shift, jal;
        logic [3:0]  aluc;
        logic [31:0] a, b, imm, pc4;
        logic [4:0]  rn;
        logic [2:0]  md;
    } ins_t;

    typedef struct {
        logic [31:0] ealu;
        logic        estall, mwreg, mm2reg, mwmem;
        logic [31:0] malu, mb;
        logic [4:0]  mrn;
        bit          chk;
        logic [31:0] cval;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   drv_done = 1'b0;

    // Reference state: remaining stall cycles, architectural HI/LO, EX/MEM contents.
    int          stall_left = 0;
    bit          retire = 1'b0;
    bit          last_stall = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, pend_hi, pend_lo;
    logic        r_wreg = 0, r_m2reg = 0, r_wmem = 0;
    logic [31:0] r_malu = '0, r_mb = '0;
    logic [4:0]  r_mrn = '0;

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a[4:0]);
        case (c[2:0])
            3'b000: return a + b;
            3'b100: return a - b;
            3'b001: return a & b;
            3'b101: return a | b;
            3'b010: return a ^ b;
            3'b110: return b * 32'h0001_0000;
            3'b011: return b << sh;
            default: begin
                if (c[3] && b[31] && sh != 0) return (b >> sh) | ~(32'hFFFF_FFFF >> sh);
                return b >> sh;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic ins_t nop();
        ins_t i;
        i = '{wreg:0, m2reg:0, wmem:0, aluimm:0, shift:0, jal:0, aluc:4'b0,
              a:'0, b:'0, imm:'0, pc4:'0, rn:'0, md:3'b0};
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        int   r;
        i = nop();
        i.wreg = 1'($urandom); i.m2reg = 1'($urandom); i.wmem = 1'($urandom);
        i.aluimm = 1'($urandom); i.shift = 1'($urandom);
        i.jal = ($urandom_range(0, 7) == 0);
        do i.aluc = 4'($urandom_range(0, 15)); while (i.aluc == 4'b1011);
        i.a = pick(); i.b = pick(); i.imm = $urandom; i.pc4 = $urandom; i.rn = 5'($urandom);
        r = $urandom_range(0, 9);
        i.md = (r == 6) ? 3'd1 : (r == 7) ? 3'd2 : (r == 8) ? 3'd3 : (r == 9) ? 3'd4 : 3'd0;
        return i;
    endfunction

    task automatic step(input ins_t i, input bit rst, input bit chk, input logic [31:0] cval);
        exp_t        e;
        logic [31:0] a_op, b_op, res;
        bit          st;
        clrn = rst;
        ewreg = i.wreg; em2reg = i.m2reg; ewmem = i.wmem; ealuc = i.aluc;
        ealuimm = i.aluimm; eshift = i.shift; ejal = i.jal;
        ea = i.a; eb = i.b; eimm = i.imm; epc4 = i.pc4; ern = i.rn; emd = i.md;
        if (rst) begin
            stall_left = 0; retire = 0; m_hi = '0; m_lo = '0;
            r_wreg = 0; r_m2reg = 0; r_wmem = 0; r_malu = '0; r_mb = '0; r_mrn = '0;
        end else if (stall_left == 0 && !retire && (i.md == 3'd1 || i.md == 3'd2)) begin
            stall_left = 33;
            if (i.md == 3'd1) {pend_hi, pend_lo} = 64'(i.a) * 64'(i.b);
            else if (i.b == 0) begin pend_lo = 32'hFFFF_FFFF; pend_hi = i.a; end
            else begin pend_lo = i.a / i.b; pend_hi = i.a % i.b; end
        end
        st   = (stall_left > 0);
        a_op = i.shift ? 32'(i.imm[10:6]) : i.a;
        b_op = i.aluimm ? i.imm : i.b;
        if (i.jal)              res = i.pc4 + 32'd4;
        else if (i.md == 3'd3)  res = m_hi;
        else if (i.md == 3'd4)  res = m_lo;
        else                    res = ref_alu(i.aluc, a_op, b_op);
        e = '{ealu:res, estall:st, mwreg:r_wreg, mm2reg:r_m2reg, mwmem:r_wmem,
              malu:r_malu, mb:r_mb, mrn:r_mrn, chk:chk, cval:cval};
        q.push_back(e);
        last_stall = st;
        @(posedge clk); #1;
        if (!rst) begin
            if (st) begin
                r_wreg = 0; r_m2reg = 0; r_wmem = 0; r_malu = '0; r_mb = '0; r_mrn = '0;
                stall_left--;
                if (stall_left == 0) begin m_hi = pend_hi; m_lo = pend_lo; retire = 1; end
            end else begin
                r_wreg = i.wreg; r_m2reg = i.m2reg; r_wmem = i.wmem;
                r_malu = res; r_mb = i.b; r_mrn = i.rn; retire = 0;
            end
        end
    endtask

    // Upstream stages hold the instruction for as long as estall is expected.
    task automatic issue(input ins_t i, input bit chk, input logic [31:0] cval);
        step(i, 1'b0, chk, cval);
        while (last_stall) step(i, 1'b0, 1'b0, '0);
    endtask

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!(drv_done && q.size() == 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                cmp("ealu", ealu, e.ealu);
                cmp("estall", 32'(estall), 32'(e.estall));
                cmp("mwreg", 32'(mwreg), 32'(e.mwreg));
                cmp("mm2reg", 32'(mm2reg), 32'(e.mm2reg));
                cmp("mwmem", 32'(mwmem), 32'(e.mwmem));
                cmp("malu", malu, e.malu);
                cmp("mb", mb, e.mb);
                cmp("mrn", 32'(mrn), 32'(e.mrn));
                if (e.chk) cmp("ealu_const", ealu, e.cval);
            end
        end
        if (cyc >= 20000) begin
            n_err++;
            $display("FAIL timeout: %0d cycles elapsed, %0d entries pending, required 0", cyc, q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : driver
        ins_t i;
        clrn = 1'b1;
        i = nop();
        ewreg = 0; em2reg = 0; ewmem = 0; ealuc = '0; ealuimm = 0; eshift = 0; ejal = 0;
        ea = '0; eb = '0; eimm = '0; epc4 = '0; ern = '0; emd = '0;
        @(posedge clk); #1;
        step(i, 1'b1, 1'b0, '0);
        step(i, 1'b1, 1'b0, '0);

        i = nop(); i.a = 7; i.b = 5; i.aluc = 4'b0100; i.wreg = 1; i.rn = 3;
        issue(i, 1'b1, 32'd2);
        i = nop(); i.shift = 1; i.imm = 32'd4 << 6; i.b = 32'h8000_0000; i.aluc = 4'b1111;
        issue(i, 1'b1, 32'hF800_0000);
        i.aluc = 4'b0111;
        issue(i, 1'b1, 32'h0800_0000);
        i = nop(); i.jal = 1; i.pc4 = 32'h100; i.aluc = 4'b0101; i.a = 32'h55;
        issue(i, 1'b1, 32'h104);

        i = nop(); i.md = 1; i.a = 32'hFFFF_FFFF; i.b = 2; i.wreg = 1; i.rn = 9;
        issue(i, 1'b0, '0);
        i = nop(); i.md = 4; issue(i, 1'b1, 32'hFFFF_FFFE);
        i = nop(); i.md = 3; issue(i, 1'b1, 32'h1);

        i = nop(); i.md = 2; i.a = 100; i.b = 7;
        issue(i, 1'b0, '0);
        i = nop(); i.md = 4; issue(i, 1'b1, 32'd14);
        i = nop(); i.md = 3; issue(i, 1'b1, 32'd2);
        i = nop(); i.md = 2; i.a = 9; i.b = 0;
        issue(i, 1'b0, '0);
        i = nop(); i.md = 4; issue(i, 1'b1, 32'hFFFF_FFFF);
        i = nop(); i.md = 3; issue(i, 1'b1, 32'd9);

        // Abort a multu in the middle of its iterations.
        i = nop(); i.md = 1; i.a = 32'h1234_5678; i.b = 32'h9ABC; i.wreg = 1; i.rn = 4;
        for (int k = 0; k < 11; k++) step(i, 1'b0, 1'b0, '0);
        step(i, 1'b1, 1'b0, '0);
        i = nop(); i.md = 3; issue(i, 1'b1, 32'd0);
        i = nop(); i.md = 4; issue(i, 1'b1, 32'd0);
        i = nop(); i.a = 3; i.b = 4; i.wreg = 1; i.rn = 7;
        issue(i, 1'b1, 32'd7);

        for (int n = 0; n < 80; n++) begin
            i = rand_ins();
            issue(i, 1'b0, '0);
        end
        i = nop();
        step(i, 1'b0, 1'b0, '0);
        drv_done = 1'b1;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
